// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // The index needs at least one bit, even when there is only a single nibble.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle of the nibble-serial adder.
interface nsa_if #(parameter int NIBBLES = 4);

    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sout;
    logic         cout;
    logic         ovf;

    modport master (output start, ain, bin, cin, input busy, done, sout, cout, ovf);
    modport slave  (input start, ain, bin, cin, output busy, done, sout, cout, ovf);

endinterface

// File: rtl/nib_add4.sv
// Combinational 4-bit add slice with carry in and carry out.
module nib_add4
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit slice, least-significant nibble first.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input logic  clk,
    input logic  rst,
    nsa_if.slave bus
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    sout_r;
    logic            cout_r;
    logic            ovf_r;

    logic            accept_s;
    logic            last_s;
    logic [NIB_W-1:0] a_nib_s;
    logic [NIB_W-1:0] b_nib_s;
    logic [NIB_W-1:0] sum_nib_s;
    logic            co_s;

    // A request is taken whenever no nibbles are in flight.
    assign accept_s = bus.start && (state_r != RUN);
    assign last_s   = (idx_r == IW'(NIBBLES - 1));
    assign a_nib_s  = a_r[NIB_W * int'(idx_r) +: NIB_W];
    assign b_nib_s  = b_r[NIB_W * int'(idx_r) +: NIB_W];

    nib_add4 u_slice (
        .a  (a_nib_s),
        .b  (b_nib_s),
        .ci (carry_r),
        .s  (sum_nib_s),
        .co (co_s)
    );

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_nxt_s = RUN;
                else           state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = RUN;
            end
            DONE: begin
                if (bus.start) state_nxt_s = RUN;
                else           state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Operand capture, per-nibble accumulation and final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
            sout_r  <= {W{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= bus.ain;
            b_r     <= bus.bin;
            carry_r <= bus.cin;
            idx_r   <= {IW{1'b0}};
            sout_r  <= {W{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state_r == RUN) begin
            sout_r[NIB_W * int'(idx_r) +: NIB_W] <= sum_nib_s;
            carry_r <= co_s;
            if (last_s) begin
                // idx parks on the top nibble instead of wrapping.
                cout_r <= co_s;
                ovf_r  <= (a_r[W-1] == b_r[W-1]) && (sum_nib_s[NIB_W-1] != a_r[W-1]);
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end
    end

    assign bus.busy = (state_r == RUN);
    assign bus.done = (state_r == DONE);
    assign bus.sout = sout_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed table, handshake/reset sequences and random sweeps at 1, 4 and 8 nibbles.
module tb_nibble_serial_adder;

    logic clk;
    logic rst;
    int   sel;
    logic        start_v;
    logic [31:0] a_v;
    logic [31:0] b_v;
    logic        c_v;

    logic        m_done;
    logic        m_busy;
    logic [31:0] m_sout;
    logic        m_cout;
    logic        m_ovf;

    int n_pass;
    int n_total;

    nsa_if #(.NIBBLES(4)) if4 ();
    nsa_if #(.NIBBLES(1)) if1 ();
    nsa_if #(.NIBBLES(8)) if8 ();

    nibble_serial_adder #(.NIBBLES(4)) d4 (.clk(clk), .rst(rst), .bus(if4));
    nibble_serial_adder #(.NIBBLES(1)) d1 (.clk(clk), .rst(rst), .bus(if1));
    nibble_serial_adder #(.NIBBLES(8)) d8 (.clk(clk), .rst(rst), .bus(if8));

    assign if4.start = start_v && (sel == 4);
    assign if4.ain   = a_v[15:0];
    assign if4.bin   = b_v[15:0];
    assign if4.cin   = c_v;
    assign if1.start = start_v && (sel == 1);
    assign if1.ain   = a_v[3:0];
    assign if1.bin   = b_v[3:0];
    assign if1.cin   = c_v;
    assign if8.start = start_v && (sel == 8);
    assign if8.ain   = a_v;
    assign if8.bin   = b_v;
    assign if8.cin   = c_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe whichever instance is currently selected.
    always_comb begin
        m_done = if4.done;
        m_busy = if4.busy;
        m_sout = {16'd0, if4.sout};
        m_cout = if4.cout;
        m_ovf  = if4.ovf;
        case (sel)
            1: begin
                m_done = if1.done; m_busy = if1.busy; m_sout = {28'd0, if1.sout};
                m_cout = if1.cout; m_ovf = if1.ovf;
            end
            8: begin
                m_done = if8.done; m_busy = if8.busy; m_sout = if8.sout;
                m_cout = if8.cout; m_ovf = if8.ovf;
            end
            default: begin end
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: plain unsigned and signed integer sums of the operands.
    function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic c, output logic [31:0] s, output logic co,
                                    output logic ov);
        longint one, ua, ub, us, sa, sb, ss, lim;
        one = 64'sd1;
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        us  = ua + ub + longint'(c);
        s   = 32'(us & ((one << w) - one));
        co  = us[w];
        sa  = a[w-1] ? ua - (one << w) : ua;
        sb  = b[w-1] ? ub - (one << w) : ub;
        ss  = sa + sb + longint'(c);
        lim = one << (w - 1);
        ov  = (ss >= lim) || (ss < -lim);
    endfunction

    // Present a request for one edge, then scramble the operand inputs.
    task automatic launch(input int n, input logic [31:0] a, input logic [31:0] b, input logic c);
        sel = n; start_v = 1'b1; a_v = a; b_v = b; c_v = c;
        @(negedge clk);
        start_v = 1'b0; a_v = $urandom; b_v = $urandom; c_v = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!m_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [15:0] exp_p [4];
        logic [31:0] rs, ra, rb, mask;
        logic        rco, rov, rc;
        int          lat, lat2, w, cnt, seen;
        int          ns [3];

        n_pass = 0; n_total = 0;
        sel = 4; start_v = 1'b0; a_v = 32'd0; b_v = 32'd0; c_v = 1'b0;
        rst = 1'b1;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        exp_p  = '{16'h0005, 16'h0055, 16'h0555, 16'h5555};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy_done", {m_busy, m_done}, 64'd0);
        chk("reset_results", {m_sout, m_cout, m_ovf}, 64'd0);

        // Directed vectors, issued back to back.
        foreach (tbl[i]) begin
            launch(4, {16'd0, tbl[i].a}, {16'd0, tbl[i].b}, tbl[i].c);
            wait_done(lat);
            chk("tbl_latency", lat, 5);
            chk("tbl_sout", m_sout, {16'd0, tbl[i].s});
            chk("tbl_cout", m_cout, tbl[i].co);
            chk("tbl_ovf", m_ovf, tbl[i].ov);
        end
        @(negedge clk);
        chk("done_single_cycle", {m_done, m_busy}, 64'd0);
        chk("result_hold", {m_sout, m_cout}, {32'd0, 1'b0});

        // Nibbles appear one per edge, low nibble first.
        launch(4, 32'h1234, 32'h4321, 1'b0);
        chk("prog_accept", {m_busy, m_sout}, {1'b1, 32'd0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("prog_sout", m_sout, {16'd0, exp_p[k]});
        end
        chk("prog_done", m_done, 1'b1);

        // Carry ripples through every nibble with all-zero intermediate sums.
        @(negedge clk);
        launch(4, 32'hFFFF, 32'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ripple_sout", m_sout, 64'd0);
        end
        chk("ripple_done_cout", {m_done, m_cout}, 64'd3);

        // Start pulses while busy are ignored.
        @(negedge clk);
        launch(4, 32'h1111, 32'h2222, 1'b0);
        @(negedge clk);
        start_v = 1'b1; a_v = 32'h7777; b_v = 32'h7777; c_v = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_v = 1'b0;
        lat = 4;
        while (!m_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_latency", lat, 5);
        chk("ignore_sout", {m_sout, m_cout, m_ovf}, {32'h3333, 2'b00});

        // Start held in DONE: accepted immediately, done pulses NIBBLES+1 apart.
        launch(4, 32'h0F0F, 32'h0101, 1'b1);
        chk("b2b_no_idle", {m_busy, m_done}, 64'd2);
        wait_done(lat2);
        chk("b2b_spacing", lat2, 5);
        chk("b2b_sout", {m_sout, m_cout}, {32'h1011, 1'b0});

        // Reset mid-run discards the operation.
        @(negedge clk);
        launch(4, 32'hABCD, 32'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", {m_busy, m_done, m_sout, m_cout, m_ovf}, 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_done) seen++;
        end
        chk("midrst_no_done", seen, 0);

        // Reset beats a simultaneous start.
        sel = 4; start_v = 1'b1; a_v = 32'h1; b_v = 32'h1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_v = 1'b0;
        chk("rst_beats_start", {m_busy, m_done}, 64'd0);

        // Random sweeps against the integer reference.
        ns = '{1, 8, 4};
        foreach (ns[j]) begin
            w    = 4 * ns[j];
            mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
            cnt  = (ns[j] == 4) ? 200 : 2000;
            for (int i = 0; i < cnt; i++) begin
                ra = $urandom & mask;
                rb = $urandom & mask;
                rc = 1'($urandom);
                launch(ns[j], ra, rb, rc);
                wait_done(lat);
                ref_add(w, ra, rb, rc, rs, rco, rov);
                chk("rnd_latency", lat, ns[j] + 1);
                chk("rnd_sum", {m_cout, m_sout}, {rco, rs});
                chk("rnd_ovf", m_ovf, rov);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder that computes a W-bit sum (W = 4·NIBBLES) one 4-bit nibble per clock, least-significant nibble first, through a single 4-bit add slice. Carry is registered between nibbles. It sits in the arithmetic datapath next to the 4-bit adder stages and feeds wide sums to downstream consumers over a start/busy/done handshake, trading latency for a single slice of adder hardware.

## Interface

Parameters:
- NIBBLES, default 4: number of 4-bit nibbles; W = 4·NIBBLES; legal range 1–16.

Ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; accepted only when busy=0.
- ain  in  W  operand A, sampled on the accepting edge only.
- bin  in  W  operand B, sampled on the accepting edge only.
- cin  in  1  carry-in to nibble 0, sampled on the accepting edge.
- busy  out  1  high while nibbles are being processed.
- done  out  1  single-cycle pulse; result valid.
- sout  out  W  sum register.
- cout  out  1  final carry-out.
- ovf  out  1  two's-complement overflow of the W-bit sum.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→RUN while idx < NIBBLES-1.
  - RUN→DONE on the edge that processes nibble NIBBLES-1.
  - DONE→RUN on start, otherwise DONE→IDLE.
- Accepting edge (start=1 with state IDLE or DONE):
  - latch ain/bin into operand registers;
  - carry_reg ← cin; idx ← 0; sout ← 0; cout ← 0; ovf ← 0.
- Each RUN edge:
  - {c, s} = a[idx] + b[idx] + carry_reg, full 5-bit add with no truncation;
  - sout[4·idx+3 : 4·idx] ← s; carry_reg ← c; idx ← idx+1.
- Last nibble edge:
  - cout ← c;
  - ovf ← (a_msb == b_msb) && (s[3] != a_msb), where a_msb/b_msb are operand bit W-1.
- busy = (state == RUN). done = (state == DONE).
- start while busy=1 is ignored: no effect, not queued. Operands are not re-sampled.
- sout/cout/ovf hold their values from DONE until the next accepting edge.
- idx width is clog2(NIBBLES), minimum 1 bit. It never wraps past NIBBLES-1.
- rst=1 at any edge, including mid-RUN:
  - state ← IDLE; busy=0; done=0; sout=0; cout=0; ovf=0; idx=0; carry_reg=0;
  - the in-flight operation is discarded.
- rst and start in the same edge: rst wins.

## Timing

- Accepting edge E0 → busy=1 from E0 through E(NIBBLES).
- Nibble k is written on edge E(k+1).
- done=1 for exactly the cycle after E(NIBBLES). Latency from start to done is NIBBLES+1 cycles.
- Back-to-back: start held high during the DONE cycle is accepted. The next done follows NIBBLES+1 cycles later, giving throughput of one sum per NIBBLES+1 cycles.
- NIBBLES=1: RUN lasts one cycle, and done appears 2 cycles after start.
- Operand inputs may change freely after E0.

## Structure

- Shared package (nsa_pkg):
  - state enum {IDLE, RUN, DONE};
  - NIB_W = 4 constant;
  - function computing idx width.
- Sub-module nib_add4: purely combinational 4-bit slice (a[3:0], b[3:0], ci → s[3:0], co). It is instantiated once.
- Top holds the FSM, operand registers, carry_reg, idx, and the result registers.

## Test plan

- Reset: assert rst for 2 cycles mid-RUN → next cycle busy=0, done=0, sout=0, cout=0, ovf=0; no done pulse follows.
- Basic, NIBBLES=4: ain=16'h1234, bin=16'h4321, cin=0 → done 5 cycles after start; sout=16'h5555, cout=0, ovf=0.
- Carry ripple across nibbles: ain=16'hFFFF, bin=16'h0000, cin=1 → sout=16'h0000, cout=1, ovf=0. Intermediate sout nibbles are 0 as each RUN edge passes.
- Signed overflow: ain=16'h7FFF, bin=16'h0001, cin=0 → sout=16'h8000, cout=0, ovf=1. Also ain=16'h8000, bin=16'h8000 → sout=0, cout=1, ovf=1.
- Handshake:
  - start pulsed on cycles 2 and 3 after an accepted start → ignored; the result matches the first operands.
  - start held during DONE → second op accepted with no IDLE cycle; done pulses exactly NIBBLES+1 cycles apart.
- Parameter sweep: NIBBLES=1 and NIBBLES=8 against 2000 random operand/cin triples checked against a reference {cout, sout} = ain + bin + cin, plus a signed ovf check.
